// File: rtl/conv2d_stream_engine.sv
// KxK signed 2-D convolution over an IMG_W x IMG_H image with run-time stride; one result per pixel on a valid/ready port.
// Define CONV_RELU_EN to clamp negative results to zero at the MAC->OUT transition.
module conv2d_stream_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_kern_base,
  input  logic [2:0]        i_stride,
  output logic              o_src_rd,
  output logic [ADDR_W-1:0] o_src_addr,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_kern_rd,
  output logic [ADDR_W-1:0] o_kern_addr,
  input  logic [DATA_W-1:0] i_kern_data,
  output logic [ACC_W-1:0]  o_res_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int KK = K * K;
  localparam int IW = $clog2(KK + 1);
  localparam int RW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_MAC, S_OUT, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]        r_src_base, r_kern_base, r_ox_off, r_oy_off;
  logic [2:0]               r_stride;
  logic [IW-1:0]            r_idx, r_rd_idx;
  logic [RW-1:0]            r_r, r_c;
  logic                     r_rd_d, r_err;
  logic [ACC_W-1:0]         r_acc, r_res;
  logic signed [DATA_W-1:0] r_kern [KK];

  logic                         w_start_ok, w_idx_end, w_issue;
  logic                         w_last_x, w_last_y, w_last_px;
  logic signed [2*DATA_W-1:0]   w_prod;
  logic [ACC_W+2*DATA_W-1:0]    w_prod_wide;
  logic [ACC_W-1:0]             w_sum, w_res_nxt;
  logic [ADDR_W-1:0]            w_src_addr;

  assign w_start_ok = i_start && (i_stride != 3'd0);
  assign w_idx_end  = (r_idx == IW'(KK));
  assign w_issue    = ((r_state == S_LOAD_K) || (r_state == S_MAC)) && !w_idx_end;

  // Last column/row reached when one more stride would push the window past the edge.
  assign w_last_x  = (int'(r_ox_off) + int'(r_stride) + K) > IMG_W;
  assign w_last_y  = (int'(r_oy_off) + int'(r_stride) + K) > IMG_H;
  assign w_last_px = w_last_x && w_last_y;

  assign w_prod      = $signed(i_src_data) * r_kern[r_rd_idx];
  assign w_prod_wide = {{ACC_W{w_prod[2*DATA_W-1]}}, w_prod};
  assign w_sum       = r_acc + w_prod_wide[ACC_W-1:0];
`ifdef CONV_RELU_EN
  assign w_res_nxt = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_res_nxt = w_sum;
`endif

  assign w_src_addr = r_src_base +
    ADDR_W'((int'(r_oy_off) + int'(r_r)) * IMG_W + int'(r_ox_off) + int'(r_c));

  assign o_kern_rd   = w_issue && (r_state == S_LOAD_K);
  assign o_kern_addr = o_kern_rd ? (r_kern_base + ADDR_W'(r_idx)) : '0;
  assign o_src_rd    = w_issue && (r_state == S_MAC);
  assign o_src_addr  = o_src_rd ? w_src_addr : '0;
  assign o_res_data  = r_res;
  assign o_res_valid = (r_state == S_OUT);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_nxt = S_LOAD_K;
      S_LOAD_K: if (w_idx_end) w_state_nxt = S_MAC;
      S_MAC:    if (w_idx_end) w_state_nxt = S_OUT;
      S_OUT:    if (i_res_ready) w_state_nxt = w_last_px ? S_DONE : S_MAC;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_src_base  <= '0;
      r_kern_base <= '0;
      r_stride    <= '0;
      r_ox_off    <= '0;
      r_oy_off    <= '0;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_rd_d      <= 1'b0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_res       <= '0;
    end else begin
      r_err  <= (r_state == S_IDLE) && i_start && (i_stride == 3'd0);
      r_rd_d <= w_issue;
      if (w_issue) r_rd_idx <= r_idx;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_src_base  <= i_src_base;
            r_kern_base <= i_kern_base;
            r_stride    <= i_stride;
            r_ox_off    <= '0;
            r_oy_off    <= '0;
            r_idx       <= '0;
            r_r         <= '0;
            r_c         <= '0;
          end
        end
        S_LOAD_K, S_MAC: begin
          if (w_issue) begin
            r_idx <= r_idx + 1'b1;
            if (r_c == RW'(K - 1)) begin
              r_c <= '0;
              r_r <= r_r + 1'b1;
            end else begin
              r_c <= r_c + 1'b1;
            end
          end else begin
            r_idx <= '0;
            r_r   <= '0;
            r_c   <= '0;
          end
          // Clear on the first read; data returns one cycle later, so no overlap with accumulation.
          if (r_state == S_MAC) begin
            if (w_issue && (r_idx == '0)) r_acc <= '0;
            else if (r_rd_d)              r_acc <= w_sum;
            if (w_idx_end) r_res <= w_res_nxt;
          end
        end
        S_OUT: begin
          if (i_res_ready && !w_last_px) begin
            if (w_last_x) begin
              r_ox_off <= '0;
              r_oy_off <= r_oy_off + ADDR_W'(r_stride);
            end else begin
              r_ox_off <= r_ox_off + ADDR_W'(r_stride);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if ((r_state == S_LOAD_K) && r_rd_d) r_kern[r_rd_idx] <= i_kern_data;
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine on a 5x5 image with a 3x3 kernel; results are scored against a software model.
module tb_conv2d_stream_engine;
  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int ADDR_W = 16;
  localparam int ACC_W  = 24;
  localparam int KK     = K * K;
  localparam int SB     = 8;
  localparam int KB     = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        stride = 3'd0;
  logic              src_rd, kern_rd;
  logic [ADDR_W-1:0] src_addr, kern_addr;
  logic [DATA_W-1:0] src_data = '0;
  logic [DATA_W-1:0] kern_data = '0;
  logic [ACC_W-1:0]  res_data;
  logic              res_valid, busy, done, err;
  logic              res_ready = 1'b1;

  logic [7:0]        src_mem  [256];
  logic [7:0]        kern_mem [256];
  logic [ACC_W-1:0]  exp_q [$];
  logic [ACC_W-1:0]  res_log [$];
  logic [ADDR_W-1:0] src_log [9];
  int                nsrc;
  int                errors = 0;
  int                checks = 0;

  conv2d_stream_engine #(
    .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .ACC_W(ACC_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_src_base(ADDR_W'(SB)), .i_kern_base(ADDR_W'(KB)), .i_stride(stride),
    .o_src_rd(src_rd), .o_src_addr(src_addr), .i_src_data(src_data),
    .o_kern_rd(kern_rd), .o_kern_addr(kern_addr), .i_kern_data(kern_data),
    .o_res_data(res_data), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // SRAM models with one-cycle read latency.
  always @(posedge clk) begin
    if (src_rd)  src_data  <= src_mem[src_addr[7:0]];
    if (kern_rd) kern_data <= kern_mem[kern_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] model(input int oy, input int ox, input int s);
    logic [ACC_W-1:0]    acc;
    logic signed [15:0]  p;
    acc = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        p = $signed(src_mem[8'(SB + (oy * s + r) * IMG_W + ox * s + c)]) *
            $signed(kern_mem[8'(KB + r * K + c)]);
        acc = acc + ACC_W'(p);
      end
`ifdef CONV_RELU_EN
    if (acc[ACC_W-1]) acc = '0;
`endif
    return acc;
  endfunction

  task automatic run_job(input int s, input bit bp, input bit mid_start, input bit abort);
    int ow, oh, n, cyc, hold, xfers, exp_cyc;
    bit got_done, in_out;
    logic [ACC_W-1:0] held;
    ow = (IMG_W - K) / s + 1;
    oh = (IMG_H - K) / s + 1;
    n  = ow * oh;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) exp_q.push_back(model(oy, ox, s));
    res_log.delete();
    nsrc = 0; cyc = 0; hold = 0; xfers = 0; got_done = 0; in_out = 0; held = '0;
    exp_cyc = 1 + (KK + 1) + n * (KK + 2) + (bp ? n * 5 : 0) + 1;
    @(posedge clk); #1;
    start = 1'b1; stride = 3'(s); res_ready = 1'b1;
    while (cyc < 3000 && !got_done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin start = 1'b0; stride = 3'd5; end
      if (mid_start && cyc == 20) start = 1'b1;
      if (mid_start && cyc == 21) start = 1'b0;
      chk("rd_exclusive", {63'd0, src_rd && kern_rd}, 64'd0);
      if (src_rd && nsrc < 9) begin src_log[nsrc] = src_addr; nsrc++; end
      if (abort && xfers == 1 && src_rd) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs_zero",
            {src_rd, src_addr, kern_rd, kern_addr, res_data, res_valid, busy, done, err}, 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (done) got_done = 1;
      else if (res_valid) begin
        chk("no_reads_in_out", {62'd0, src_rd, kern_rd}, 64'd0);
        if (!in_out) begin held = res_data; in_out = 1; hold = 0; end
        else chk("res_stable", 64'(res_data), 64'(held));
        if (bp && hold < 5) begin
          res_ready = 1'b0;
          hold++;
        end else begin
          res_ready = 1'b1;
          if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
          else chk("result", 64'(res_data), 64'(exp_q.pop_front()));
          res_log.push_back(res_data);
          xfers++;
          in_out = 0;
        end
      end else if (in_out) chk("valid_held", {63'd0, res_valid}, 64'd1);
    end
    res_ready = 1'b1;
    chk("done_seen", {63'd0, got_done}, 64'd1);
    chk("job_cycles", 64'(cyc), 64'(exp_cyc));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [ACC_W-1:0] neg_exp;
    int s2_addr [9];
    int s2_res [4];
    s2_addr = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    s2_res  = '{54, 72, 144, 162};

    for (int i = 0; i < 256; i++) begin src_mem[i] = '0; kern_mem[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {src_rd, src_addr, kern_rd, kern_addr, res_data, res_valid, busy, done, err}, 64'd0);
    rst_n = 1'b1;

    // Ramp image, all-ones kernel, stride 1 and 2.
    for (int i = 0; i < 25; i++) src_mem[SB + i] = 8'(i);
    for (int i = 0; i < KK; i++) kern_mem[KB + i] = 8'd1;
    run_job(1, 0, 0, 0);
    run_job(2, 0, 0, 0);
    for (int i = 0; i < 9; i++) chk("s2_src_addr", 64'(src_log[i]), 64'(SB + s2_addr[i]));
    chk("s2_count", 64'(res_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < res_log.size(); i++) chk("s2_value", 64'(res_log[i]), 64'(s2_res[i]));

    run_job(2, 1, 0, 0);

    // Asymmetric kernel and random image to expose row/column mix-ups; second start mid-job.
    for (int i = 0; i < KK; i++) kern_mem[KB + i] = 8'(i - 4);
    for (int i = 0; i < 25; i++) src_mem[SB + i] = 8'($urandom_range(0, 255));
    run_job(1, 0, 1, 0);

    // Large negative sum.
    for (int i = 0; i < KK; i++) kern_mem[KB + i] = 8'hFF;
    for (int i = 0; i < 25; i++) src_mem[SB + i] = 8'd127;
    run_job(2, 0, 0, 0);
`ifdef CONV_RELU_EN
    neg_exp = '0;
`else
    neg_exp = ACC_W'(-1143);
`endif
    if (res_log.size() > 0) chk("neg_result", 64'(res_log[0]), 64'(neg_exp));
    else chk("neg_count", 64'(res_log.size()), 64'd4);

    // Zero stride is rejected.
    @(posedge clk); #1;
    start = 1'b1; stride = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("err_pulse", {62'd0, err, busy}, 64'd2);
    start = 1'b0;
    @(negedge clk);
    chk("err_cleared", {62'd0, err, busy}, 64'd0);

    // Reset during pixel 2, then a clean job.
    for (int i = 0; i < 25; i++) src_mem[SB + i] = 8'(i);
    for (int i = 0; i < KK; i++) kern_mem[KB + i] = 8'(1 + (i % 3));
    run_job(1, 0, 0, 1);
    run_job(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
